// File: rtl/bus_arbiter_if.sv
// Connection bundle for bus_arbiter: per-master request/response lanes plus the shared bus side.
// The arbiter uses the master modport (it masters the shared bus); masters and slaves attach via slave.
interface bus_arbiter_if #(
    parameter int MASTER_COUNT = 3
);
    localparam int GW = $clog2(MASTER_COUNT);

    logic [32*MASTER_COUNT-1:0] m_addr;
    logic [32*MASTER_COUNT-1:0] m_data_out;
    logic [31:0]                m_data_in;
    logic [MASTER_COUNT-1:0]    m_wr;
    logic [MASTER_COUNT-1:0]    m_rd;
    logic [4*MASTER_COUNT-1:0]  m_mask;
    logic [MASTER_COUNT-1:0]    m_fc;
    logic [MASTER_COUNT-1:0]    m_err;
    logic [31:0]                addr_bus;
    logic                       wr_bus;
    logic                       rd_bus;
    logic [3:0]                 data_mask_bus;
    logic                       fc_bus;
    logic                       bus_busy;
    logic [GW-1:0]              grant_idx;

    modport master (
        input  m_addr, m_data_out, m_wr, m_rd, m_mask, fc_bus,
        output m_data_in, m_fc, m_err, addr_bus, wr_bus, rd_bus, data_mask_bus,
               bus_busy, grant_idx
    );

    modport slave (
        output m_addr, m_data_out, m_wr, m_rd, m_mask, fc_bus,
        input  m_data_in, m_fc, m_err, addr_bus, wr_bus, rd_bus, data_mask_bus,
               bus_busy, grant_idx
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one system bus between MASTER_COUNT masters, with an idle gap per transaction.
// Optional bus-timeout abort is enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
    parameter int MASTER_COUNT = 3
`ifdef BUS_ARBITER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_arbiter_if.master        bus,
    inout  wire  [31:0]          data_bus
);
    localparam int GW = $clog2(MASTER_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_q, last_d;
    logic [MASTER_COUNT-1:0] req;
    logic [GW-1:0]           pick;
    logic                    pick_valid;
    logic                    fc_hit;
    logic                    busy_st;
    logic                    abort_st;
    logic [31:0]             addr_arr [MASTER_COUNT];
    logic [31:0]             dout_arr [MASTER_COUNT];
    logic [3:0]              mask_arr [MASTER_COUNT];

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // rd and wr together is an invalid request and is never granted
    assign req      = bus.m_rd ^ bus.m_wr;
    assign fc_hit   = (bus.fc_bus === 1'b1);
    assign busy_st  = (state_q == S_BUSY);
    assign abort_st = (state_q == S_ABORT);

    for (genvar gi = 0; gi < MASTER_COUNT; gi++) begin : g_master
        assign addr_arr[gi] = bus.m_addr[32*gi +: 32];
        assign dout_arr[gi] = bus.m_data_out[32*gi +: 32];
        assign mask_arr[gi] = bus.m_mask[4*gi +: 4];
        assign bus.m_fc[gi] = (grant_q == GW'(gi)) && ((busy_st && fc_hit) || abort_st);
`ifdef BUS_ARBITER_TIMEOUT_EN
        assign bus.m_err[gi] = (grant_q == GW'(gi)) && abort_st;
`else
        assign bus.m_err[gi] = 1'b0;
`endif
    end

    // First requester after the last granted index wins
    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick       = '0;
        cand       = 0;
        for (int k = 1; k <= MASTER_COUNT; k++) begin
            cand = int'(last_q) + k;
            if (cand >= MASTER_COUNT) cand = cand - MASTER_COUNT;
            if (!pick_valid && req[GW'(cand)]) begin
                pick_valid = 1'b1;
                pick       = GW'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= GW'(MASTER_COUNT - 1);
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_BUSY;
                    grant_d = pick;
                    last_d  = pick;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUSY: begin
                // Leaving through IDLE guarantees every slave sees a cycle with no strobe
                if (!req[grant_q]) begin
                    state_d = S_IDLE;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (!fc_hit) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) state_d = S_ABORT;
                end
`endif
            end
`ifdef BUS_ARBITER_TIMEOUT_EN
            S_ABORT: begin
                if (!req[grant_q]) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.addr_bus      = busy_st ? addr_arr[grant_q] : '0;
    assign bus.data_mask_bus = busy_st ? mask_arr[grant_q] : '0;
    assign bus.rd_bus        = busy_st && bus.m_rd[grant_q];
    assign bus.wr_bus        = busy_st && bus.m_wr[grant_q];
    assign data_bus          = (busy_st && bus.m_wr[grant_q]) ? dout_arr[grant_q] : 'z;
    assign bus.m_data_in     = data_bus;
    assign bus.bus_busy      = (state_q != S_IDLE);
    assign bus.grant_idx     = grant_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, contention order, read/write drive, back-to-back, async reset, timeout.
module tb_bus_arbiter;
    localparam int MC = 3;

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] data_bus;
    logic        slave_drive;
    logic [31:0] slave_data;
    int          checks = 0;
    int          errors = 0;

    bus_arbiter_if #(.MASTER_COUNT(MC)) bus ();

    assign data_bus = slave_drive ? slave_data : 32'bz;

    bus_arbiter #(
        .MASTER_COUNT(MC)
`ifdef BUS_ARBITER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .data_bus (data_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int idx, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
        bus.m_rd[idx]              = rd;
        bus.m_wr[idx]              = wr;
        bus.m_addr[32*idx +: 32]   = addr;
        bus.m_data_out[32*idx +: 32] = wdata;
        bus.m_mask[4*idx +: 4]     = mask;
    endtask

    // Called at a negedge while master idx holds the grant; completes it and checks the idle gap
    task automatic serve(input int idx, input logic [31:0] addr, input bit is_wr,
                         input logic [31:0] val, input logic [3:0] mask, input bit reraise);
        logic [MC-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        check("grant_idx", 32'(bus.grant_idx), 32'(idx));
        check("bus_busy", 32'(bus.bus_busy), 32'd1);
        check("addr_bus", bus.addr_bus, addr);
        check("mask_bus", 32'(bus.data_mask_bus), 32'(mask));
        check("rd_bus", 32'(bus.rd_bus), 32'(!is_wr));
        check("wr_bus", 32'(bus.wr_bus), 32'(is_wr));
        check("fc_before", 32'(bus.m_fc), 32'd0);
        if (is_wr) begin
            check("data_bus_wr", data_bus, val);
        end else begin
            slave_data  = val;
            slave_drive = 1'b1;
        end
        bus.fc_bus = 1'b1;
        #1;
        check("m_fc", 32'(bus.m_fc), 32'(onehot));
        check("m_err", 32'(bus.m_err), 32'd0);
        if (!is_wr) check("m_data_in", bus.m_data_in, val);
        bus.m_rd[idx] = 1'b0;
        bus.m_wr[idx] = 1'b0;
        bus.fc_bus    = 1'b0;
        slave_drive   = 1'b0;
        $display("txn master=%0d %s addr=0x%08h data=0x%08h", idx, is_wr ? "WR" : "RD", addr, val);
        @(negedge clk);
        check("idle_busy", 32'(bus.bus_busy), 32'd0);
        check("idle_rd", 32'(bus.rd_bus), 32'd0);
        check("idle_wr", 32'(bus.wr_bus), 32'd0);
        check("idle_addr", bus.addr_bus, 32'd0);
        check("idle_fc", 32'(bus.m_fc), 32'd0);
        check("idle_data_released", 32'(data_bus === val), 32'd0);
        if (reraise) set_req(idx, !is_wr, is_wr, addr, val, mask);
    endtask

    initial begin
        rst            = 1'b1;
        bus.m_addr     = '0;
        bus.m_data_out = '0;
        bus.m_wr       = '0;
        bus.m_rd       = '0;
        bus.m_mask     = '0;
        bus.fc_bus     = 1'b0;
        slave_drive    = 1'b0;
        slave_data     = '0;
        repeat (2) @(negedge clk);

        check("rst_busy", 32'(bus.bus_busy), 32'd0);
        check("rst_grant", 32'(bus.grant_idx), 32'd0);
        check("rst_strobes", 32'({bus.rd_bus, bus.wr_bus}), 32'd0);
        check("rst_addr", bus.addr_bus, 32'd0);
        check("rst_mask", 32'(bus.data_mask_bus), 32'd0);
        check("rst_fc", 32'(bus.m_fc), 32'd0);
        check("rst_err", 32'(bus.m_err), 32'd0);
        $display("txn reset released");
        rst = 1'b0;
        @(negedge clk);

        // Contention from reset: expect 0,1,2,0
        set_req(0, 1, 0, 32'h0000_00A0, 32'h0, 4'hF);
        set_req(1, 1, 0, 32'h0000_00B0, 32'h0, 4'hF);
        set_req(2, 1, 0, 32'h0000_00C0, 32'h0, 4'hF);
        @(negedge clk);
        serve(0, 32'h0000_00A0, 1'b0, 32'h1111_0000, 4'hF, 1'b1);
        @(negedge clk);
        serve(1, 32'h0000_00B0, 1'b0, 32'h2222_0000, 4'hF, 1'b0);
        @(negedge clk);
        serve(2, 32'h0000_00C0, 1'b0, 32'h3333_0000, 4'hF, 1'b0);
        @(negedge clk);
        serve(0, 32'h0000_00A0, 1'b0, 32'h4444_0000, 4'hF, 1'b0);

        // Single read by master 1, slave answers on the second strobe cycle
        set_req(1, 1, 0, 32'h0000_0100, 32'h0, 4'hF);
        @(negedge clk);
        check("rd1_strobe", 32'(bus.rd_bus), 32'd1);
        check("rd1_nofc", 32'(bus.m_fc), 32'd0);
        @(negedge clk);
        serve(1, 32'h0000_0100, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0);

        // Write by master 2: data only on the bus while granted
        set_req(2, 0, 1, 32'h0000_0200, 32'hDEAD_BEEF, 4'h3);
        check("wr_pre_grant_z", 32'(data_bus === 32'hDEAD_BEEF), 32'd0);
        @(negedge clk);
        serve(2, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 4'h3, 1'b0);

        // Back-to-back from master 0: exactly one idle cycle
        set_req(0, 1, 0, 32'h0000_0300, 32'h0, 4'hF);
        @(negedge clk);
        serve(0, 32'h0000_0300, 1'b0, 32'h0000_0033, 4'hF, 1'b1);
        @(negedge clk);
        serve(0, 32'h0000_0300, 1'b0, 32'h0000_0034, 4'hF, 1'b0);

        // Asynchronous reset in the middle of a write by master 1
        set_req(1, 0, 1, 32'h0000_0400, 32'h55AA_55AA, 4'hF);
        @(negedge clk);
        check("pre_rst_wr", 32'(bus.wr_bus), 32'd1);
        rst = 1'b1;
        #1;
        check("async_busy", 32'(bus.bus_busy), 32'd0);
        check("async_wr", 32'(bus.wr_bus), 32'd0);
        check("async_addr", bus.addr_bus, 32'd0);
        check("async_grant", 32'(bus.grant_idx), 32'd0);
        check("async_data_released", 32'(data_bus === 32'h55AA_55AA), 32'd0);
        $display("txn async reset during master 1 write");
        set_req(0, 1, 0, 32'h0000_0500, 32'h0, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        serve(0, 32'h0000_0500, 1'b0, 32'h0000_0055, 4'hF, 1'b0);
        @(negedge clk);
        serve(1, 32'h0000_0400, 1'b1, 32'h55AA_55AA, 4'hF, 1'b0);

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Read to an unmapped address: no fc ever arrives
        set_req(0, 1, 0, 32'hDEAD_0000, 32'h0, 4'hF);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("to_busy_rd", 32'(bus.rd_bus), 32'd1);
            check("to_busy_fc", 32'(bus.m_fc), 32'd0);
        end
        @(negedge clk);
        check("abort_fc", 32'(bus.m_fc), 32'd1);
        check("abort_err", 32'(bus.m_err), 32'd1);
        check("abort_rd", 32'(bus.rd_bus), 32'd0);
        check("abort_busy", 32'(bus.bus_busy), 32'd1);
        $display("txn master=0 RD addr=0xdead0000 aborted");
        bus.m_rd[0] = 1'b0;
        @(negedge clk);
        check("post_abort_busy", 32'(bus.bus_busy), 32'd0);
        check("post_abort_fc", 32'(bus.m_fc), 32'd0);
        check("post_abort_err", 32'(bus.m_err), 32'd0);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single system bus (addr/data/wr/rd/mask/fc) between several bus masters, such as instruction fetch, data access and DMA. It sits between the masters and the bus that the memory and peripheral bus interfaces decode. Only one master's request reaches the bus at a time. The arbiter forwards the slave's fc completion back to the granted master and inserts an idle gap so every slave FSM returns to idle between transactions.

## Interface
- MASTER_COUNT, 3, number of masters (2..8); index 0 = highest initial priority
- TIMEOUT_CYCLES, 256, cycles without fc before abort (only with BUS_ARBITER_TIMEOUT_EN)
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- m_addr  input  32*MASTER_COUNT  per-master byte address, master i at [32*i+:32]
- m_data_out  input  32*MASTER_COUNT  per-master write data
- m_data_in  output  32  read data from data_bus, common to all masters
- m_wr, m_rd  input  MASTER_COUNT  per-master write/read request
- m_mask  input  4*MASTER_COUNT  per-master byte mask
- m_fc  output  MASTER_COUNT  per-master completion
- m_err  output  MASTER_COUNT  per-master abort flag (constant 0 without the macro)
- addr_bus  output  32  bus address
- data_bus  inout  32  bus data, driven only during a granted write
- wr_bus, rd_bus  output  1  bus strobes
- data_mask_bus  output  4  bus byte mask
- fc_bus  input  1  slave completion; tri-stated when no slave hits, and only logic 1 counts as ack
- bus_busy  output  1  a grant is active
- grant_idx  output  $clog2(MASTER_COUNT)  index of current or last granted master

## Operation
- Master i is requesting when m_rd[i] ^ m_wr[i]. rd==wr==1 is invalid and never granted.
- States:
  - IDLE: bus strobes 0, addr_bus/data_data_mask_bus 0, data_bus z. If any master is requesting, register the grant and go to BUSY.
  - BUSY: the granted master's addr, mask, rd and wr drive the bus. data_bus = m_data_out of the granted master when its wr=1, else z. m_fc[grant] = (fc_bus === 1). When the granted master stops requesting, go to IDLE.
  - ABORT (macro only): see Configuration.
- Round robin: the search starts at (last_grant+1) mod MASTER_COUNT and takes the first requesting master. last_grant updates at every grant.
- m_fc of non-granted masters is 0. m_data_in = data_bus continuously, and is valid only for the granted reader while its m_fc=1.
- The grant is held for a whole transaction. A master that changes addr or strobes mid-transaction is a protocol violation and is not checked.
- A granted master that drops its request before fc releases the bus normally.

## Timing
- Reset values: state IDLE, last_grant = MASTER_COUNT-1 (master 0 wins first), bus_busy 0, grant_idx 0, all strobes/addr/mask 0, data_bus z, m_fc 0, m_err 0, timeout counter 0.
- Grant latency: a request visible at edge t is on the bus from edge t, i.e. in the cycle after the request is sampled.
- m_fc follows fc_bus combinationally in the same cycle.
- Release: the edge where the granted master's request is low moves the arbiter to IDLE. At least one full idle bus cycle separates any two transactions, including back-to-back transactions from the same master. This guarantees the slaves see !req.
- Minimum transaction with a 1-cycle-fc slave: grant cycle, fc cycle, idle cycle.
- Simultaneous requests resolve at the IDLE edge using the pointer. A request arriving during BUSY waits.
- Asynchronous reset mid-transaction returns immediately to reset values. The slave sees strobes drop and returns to idle on its own.

## Configuration
- BUS_ARBITER_TIMEOUT_EN:
  - Defined: a counter clears on entry to BUSY and increments each BUSY cycle with fc_bus != 1.
  - When it reaches TIMEOUT_CYCLES, the arbiter enters ABORT.
  - In ABORT, bus strobes are 0, data_bus is z, and m_fc[grant] = m_err[grant] = 1 until that master drops its request, then IDLE.
  - A completed transaction never raises m_err.
- Undefined: no counter and no ABORT state; m_err is tied to 0. A missing slave hangs the grant until reset.

## Test plan
- Single read: master 1 reads 0x100 and the slave asserts fc 2 cycles after the strobe → addr_bus=0x100, rd_bus=1, m_fc[1]=1 in that cycle, m_data_in = slave data, then one idle cycle.
- Contention: all 3 masters request together from reset → grants follow order 0,1,2,0, with one idle cycle between transactions and the other m_fc held at 0.
- Write drive: master 2 writes 0xDEADBEEF with mask 0x3 → data_bus = 0xDEADBEEF and data_mask_bus = 0x3 only while granted, otherwise z.
- Back-to-back from one master: master 0 re-requests right after release → rd/wr_bus is low for exactly 1 cycle, then master 0 is granted again if no one else is requesting.
- Reset mid-transaction: rst asserted in BUSY → strobes 0, data_bus z, bus_busy 0 asynchronously; after release, master 0 has first priority.
- Timeout (macro, TIMEOUT_CYCLES=4): read to an unmapped address → after 4 BUSY cycles, m_fc=m_err=1 for the granted master and strobes are 0; after the request drops, the arbiter returns to IDLE.
